// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler.
// State encodings, source ids and a one-hot helper.
package uart_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  function automatic logic [1:0] src_onehot(
    input logic id
  );
    return (id == SRC1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Two-way round-robin picker for the transmit scheduler.
// A held lock pins the choice to the lock owner.
module uart_tx_sched_arb
  import uart_pkg::*;
(
  input  logic [1:0] vld,
  input  logic       ptr,
  input  logic       lock_vld,
  input  logic       lock_id,
  output logic       sel_vld,
  output logic       sel_id
);

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = ptr;
    unique case (1'b1)
      lock_vld: begin
        sel_vld = vld[lock_id];
        sel_id  = lock_id;
      end
      !lock_vld && (vld == 2'b11): begin
        sel_vld = 1'b1;
        sel_id  = ptr;
      end
      !lock_vld && (vld == 2'b01): begin
        sel_vld = 1'b1;
        sel_id  = SRC0;
      end
      !lock_vld && (vld == 2'b10): begin
        sel_vld = 1'b1;
        sel_id  = SRC1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-source transmit scheduler feeding the UART transmitter.
// Packet-locked round robin, Busy handshake and pickup watchdog.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  TX_CLK,
  input  logic                  RST,
  input  logic                  REQ0_VLD,
  input  logic [DATA_WIDTH-1:0] REQ0_DATA,
  input  logic                  REQ0_LAST,
  output logic                  REQ0_RDY,
  input  logic                  REQ1_VLD,
  input  logic [DATA_WIDTH-1:0] REQ1_DATA,
  input  logic                  REQ1_LAST,
  output logic                  REQ1_RDY,
  input  logic                  Busy,
  output logic                  F_EMPTY,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [1:0]            GNT,
  output logic                  TMO_ERR
);

  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  logic [1:0]            state;
  logic                  ptr;
  logic                  lock_vld;
  logic                  owner;
  logic                  last_q;
  logic                  tmo_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         cnt;

  logic                  sel_vld;
  logic                  sel_id;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  // While locked, owner doubles as the lock id.
  uart_tx_sched_arb u_arb (
    .vld      ({REQ1_VLD, REQ0_VLD}),
    .ptr      (ptr),
    .lock_vld (lock_vld),
    .lock_id  (owner),
    .sel_vld  (sel_vld),
    .sel_id   (sel_id)
  );

  assign accept   = (state == IDLE) && sel_vld;
  assign REQ0_RDY = accept && (sel_id == SRC0);
  assign REQ1_RDY = accept && (sel_id == SRC1);
  assign sel_data = (sel_id == SRC1) ? REQ1_DATA : REQ0_DATA;
  assign sel_last = (sel_id == SRC1) ? REQ1_LAST : REQ0_LAST;

  assign F_EMPTY = (state != LOAD);
  assign RD_DATA = data_q;
  assign TMO_ERR = tmo_q;
  assign GNT     = (lock_vld || (state != IDLE))
                   ? src_onehot(owner) : 2'b00;

  always_ff @(posedge TX_CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      ptr      <= SRC0;
      lock_vld <= 1'b0;
      owner    <= SRC0;
      last_q   <= 1'b0;
      tmo_q    <= 1'b0;
      data_q   <= '0;
      cnt      <= '0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            data_q <= sel_data;
            last_q <= sel_last;
            owner  <= sel_id;
            cnt    <= '0;
            state  <= LOAD;
            if (!sel_last) lock_vld <= 1'b1;
          end
        end
        LOAD: begin
          // Busy already high counts as pickup.
          if (Busy) begin
            state <= SEND;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            tmo_q    <= 1'b1;
            lock_vld <= 1'b0;
            ptr      <= ~owner;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SEND: begin
          if (!Busy) begin
            state <= IDLE;
            if (last_q) begin
              lock_vld <= 1'b0;
              ptr      <= ~owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
